// File: rtl/dcache_controller_if.sv
// Bus bundle for the data cache: MEM-stage request/response plus the 128-bit block-memory port.
// Handshake: the pipeline holds READ/WRITE/FUNCT3/ADDRESS/WRITEDATA stable while BUSYWAIT=1; the cache
// holds MEM_READ/MEM_WRITE/MEM_ADDRESS/MEM_WRITEDATA stable until a posedge sees MEM_BUSYWAIT=0.
interface dcache_controller_if;
   logic         READ;
   logic         WRITE;
   logic [2:0]   FUNCT3;
   logic [31:0]  ADDRESS;
   logic [31:0]  WRITEDATA;
   logic [31:0]  READDATA;
   logic         BUSYWAIT;
   logic         MEM_READ;
   logic         MEM_WRITE;
   logic [27:0]  MEM_ADDRESS;
   logic [127:0] MEM_WRITEDATA;
   logic [127:0] MEM_READDATA;
   logic         MEM_BUSYWAIT;

   modport slave (
      input  READ, WRITE, FUNCT3, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
      output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
   );

   modport master (
      output READ, WRITE, FUNCT3, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
      input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
   );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache with a 4-state miss FSM.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_controller #(
   parameter int NUM_LINES = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   dcache_controller_if.slave bus,
   output logic [1:0]       state_dbg
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]      HIT_COUNT,
   output logic [31:0]      MISS_COUNT
`endif
);

   localparam int INDEX_W = $clog2(NUM_LINES);
   localparam int TAG_W   = 28 - INDEX_W;

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] WRITEBACK = 2'd1;
   localparam logic [1:0] FETCH     = 2'd2;
   localparam logic [1:0] UPDATE    = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [NUM_LINES-1:0] valid_q, valid_d;
   logic [NUM_LINES-1:0] dirty_q, dirty_d;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [TAG_W-1:0]     tag_d  [NUM_LINES];
   logic [127:0]         data_q [NUM_LINES];
   logic [127:0]         data_d [NUM_LINES];

   logic [TAG_W-1:0]   req_tag;
   logic [INDEX_W-1:0] idx;
   logic [1:0]         word_off;
   logic [1:0]         byte_off;
   logic               access;
   logic               hit;
   logic [127:0]       line;
   logic [31:0]        word_sel;
   logic [7:0]         byte_sel;
   logic [15:0]        half_sel;
   logic [31:0]        load_val;
   logic [31:0]        store_word;

   assign req_tag  = bus.ADDRESS[31:4+INDEX_W];
   assign idx      = bus.ADDRESS[4+INDEX_W-1:4];
   assign word_off = bus.ADDRESS[3:2];
   assign byte_off = bus.ADDRESS[1:0];
   assign access   = bus.READ | bus.WRITE;
   assign hit      = valid_q[idx] && (tag_q[idx] == req_tag);
   assign line     = data_q[idx];
   assign word_sel = line[{word_off, 5'b00000} +: 32];
   assign byte_sel = word_sel[{byte_off, 3'b000} +: 8];
   assign half_sel = word_sel[{bus.ADDRESS[1], 4'b0000} +: 16];

   // Unlisted FUNCT3 encodings fall through to whole-word accesses on both paths.
   always_comb begin
      load_val = word_sel;
      case (bus.FUNCT3)
         3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_val = {24'd0, byte_sel};
         3'b101:  load_val = {16'd0, half_sel};
         default: load_val = word_sel;
      endcase
   end

   always_comb begin
      store_word = word_sel;
      case (bus.FUNCT3)
         3'b000:  store_word[{byte_off, 3'b000} +: 8] = bus.WRITEDATA[7:0];
         3'b001:  store_word[{bus.ADDRESS[1], 4'b0000} +: 16] = bus.WRITEDATA[15:0];
         default: store_word = bus.WRITEDATA;
      endcase
   end

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      dirty_d = dirty_q;
      tag_d   = tag_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (access) begin
               if (hit) begin
                  if (bus.WRITE) begin
                     data_d[idx][{word_off, 5'b00000} +: 32] = store_word;
                     dirty_d[idx] = 1'b1;
                  end
               end else if (valid_q[idx] && dirty_q[idx]) begin
                  state_d = WRITEBACK;
               end else begin
                  state_d = FETCH;
               end
            end
         end
         WRITEBACK: begin
            if (!bus.MEM_BUSYWAIT) state_d = FETCH;
         end
         FETCH: begin
            // Fill on the completing edge, while memory still presents the block.
            if (!bus.MEM_BUSYWAIT) begin
               state_d      = UPDATE;
               data_d[idx]  = bus.MEM_READDATA;
               tag_d[idx]   = req_tag;
               valid_d[idx] = 1'b1;
               dirty_d[idx] = 1'b0;
            end
         end
         UPDATE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   always_ff @(posedge CLK) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

   // Outputs are forced quiet while RESET is high so an abandoned transfer drops at once.
   always_comb begin
      bus.BUSYWAIT      = 1'b0;
      bus.READDATA      = 32'd0;
      bus.MEM_READ      = 1'b0;
      bus.MEM_WRITE     = 1'b0;
      bus.MEM_ADDRESS   = 28'd0;
      bus.MEM_WRITEDATA = 128'd0;
      if (!RESET) begin
         bus.BUSYWAIT = (state_q != IDLE) || (access && !hit);
         if (state_q == IDLE && bus.READ && !bus.WRITE && hit) bus.READDATA = load_val;
         if (state_q == WRITEBACK) begin
            bus.MEM_WRITE     = 1'b1;
            bus.MEM_ADDRESS   = {tag_q[idx], idx};
            bus.MEM_WRITEDATA = line;
         end
         if (state_q == FETCH) begin
            bus.MEM_READ    = 1'b1;
            bus.MEM_ADDRESS = bus.ADDRESS[31:4];
         end
      end
   end

   assign state_dbg = state_q;

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count_q, hit_count_d;
   logic [31:0] miss_count_q, miss_count_d;
   logic        refill_q, refill_d;

   // refill_q marks the IDLE cycle right after UPDATE, whose hit finishes a miss.
   always_comb begin
      refill_d     = (state_q == UPDATE);
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      if (state_q == IDLE && access) begin
         if (hit && !refill_q) hit_count_d = hit_count_q + 32'd1;
         if (!hit)             miss_count_d = miss_count_q + 32'd1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         hit_count_q  <= 32'd0;
         miss_count_q <= 32'd0;
         refill_q     <= 1'b0;
      end else begin
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
         refill_q     <= refill_d;
      end
   end

   assign HIT_COUNT  = hit_count_q;
   assign MISS_COUNT = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: vector table of accesses plus hand sequences for
// writeback, dropped requests, reset mid-fetch and (with DCACHE_STATS_EN) the counters.
module tb_dcache_controller;

   localparam int L = 3;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic [1:0] state_dbg;
`ifdef DCACHE_STATS_EN
   logic [31:0] HIT_COUNT, MISS_COUNT;
`endif

   dcache_controller_if bus ();

   dcache_controller #(.NUM_LINES(8)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .bus       (bus),
      .state_dbg (state_dbg)
`ifdef DCACHE_STATS_EN
      ,
      .HIT_COUNT  (HIT_COUNT),
      .MISS_COUNT (MISS_COUNT)
`endif
   );

   // ---------------- clock / reset ----------------
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- block memory model ----------------
   // A transfer completes after L held cycles; one started straight after a completion
   // needs an extra turnaround cycle.
   logic [127:0] mem [64];
   int           cnt = 0;
   bit           mem_loaded = 1'b0;

   assign bus.MEM_BUSYWAIT = (bus.MEM_READ | bus.MEM_WRITE) && (cnt != L - 1);
   assign bus.MEM_READDATA = mem[bus.MEM_ADDRESS[5:0]];

   always @(posedge CLK) begin
      if (!mem_loaded) begin
         mem[4]     <= 128'h44444444_33333333_22222222_11111111;
         mem[8]     <= 128'h88888888_77777777_66666666_55555555;
         mem[12]    <= 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
         mem_loaded <= 1'b1;
      end
      if (RESET || !(bus.MEM_READ | bus.MEM_WRITE)) begin
         cnt <= 0;
      end else if (cnt == L - 1) begin
         if (bus.MEM_WRITE) mem[bus.MEM_ADDRESS[5:0]] <= bus.MEM_WRITEDATA;
         cnt <= -1;
      end else begin
         cnt <= cnt + 1;
      end
   end

   // ---------------- bus monitor ----------------
   logic         saw_rd, saw_wr;
   logic [27:0]  rd_addr, wr_addr;
   logic [127:0] wr_data;
   int           both_high = 0;

   always @(negedge CLK) begin
      if (bus.MEM_READ) begin
         saw_rd  = 1'b1;
         rd_addr = bus.MEM_ADDRESS;
      end
      if (bus.MEM_WRITE) begin
         saw_wr  = 1'b1;
         wr_addr = bus.MEM_ADDRESS;
         wr_data = bus.MEM_WRITEDATA;
      end
      if (bus.MEM_READ && bus.MEM_WRITE) both_high++;
   end

   // ---------------- scoreboard ----------------
   int          n_cmp = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called #1 after a posedge; returns #1 after the posedge that completes the access.
   task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output int stall, output logic [31:0] rdata);
      bus.READ      = rd;
      bus.WRITE     = wr;
      bus.FUNCT3    = f3;
      bus.ADDRESS   = addr;
      bus.WRITEDATA = wdata;
      saw_rd = 1'b0;
      saw_wr = 1'b0;
      stall  = 0;
      @(negedge CLK);
      while (bus.BUSYWAIT && stall < 100) begin
         stall++;
         @(negedge CLK);
      end
      if (stall >= 100) check("busywait_timeout", 128'(stall), 128'd0);
      rdata = bus.READDATA;
      @(posedge CLK);
      #1;
      bus.READ  = 1'b0;
      bus.WRITE = 1'b0;
   endtask

   task automatic wait_mem_read(input string name);
      int n = 0;
      @(negedge CLK);
      while (!bus.MEM_READ && n < 30) begin
         n++;
         @(negedge CLK);
      end
      if (n >= 30) check(name, 128'(bus.MEM_READ), 128'd1);
   endtask

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk;
      logic [31:0] exp_rd;
      int          exp_stall;
   } vec_t;

   vec_t vecs [22];

   task automatic set_vec(input int i, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic chk, input logic [31:0] exp_rd, input int exp_stall);
      vecs[i].rd = rd;  vecs[i].wr = wr;  vecs[i].f3 = f3;
      vecs[i].addr = addr;  vecs[i].wdata = wdata;
      vecs[i].chk = chk;  vecs[i].exp_rd = exp_rd;  vecs[i].exp_stall = exp_stall;
   endtask

   task automatic run_vec(input int i);
      int          stall;
      logic [31:0] rdata;
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata, stall, rdata);
      check($sformatf("vec%0d_stall", i), 128'(stall), 128'(vecs[i].exp_stall));
      if (vecs[i].chk) begin
         exp_q.push_back(vecs[i].exp_rd);
         check($sformatf("vec%0d_readdata", i), 128'(rdata), 128'(exp_q.pop_front()));
      end
   endtask

   // ---------------- test ----------------
   initial begin
      int          stall;
      int          n;
      logic [31:0] rdata;

      bus.READ = 1'b0;  bus.WRITE = 1'b0;  bus.FUNCT3 = 3'b010;
      bus.ADDRESS = 32'd0;  bus.WRITEDATA = 32'd0;

      set_vec( 0, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0,        1'b1, 32'h11111111, 5);
      set_vec( 1, 1'b0, 1'b1, 3'b000, 32'h41, 32'h000000AB, 1'b0, 32'h0,        0);
      set_vec( 2, 1'b1, 1'b0, 3'b100, 32'h41, 32'h0,        1'b1, 32'h000000AB, 0);
      set_vec( 3, 1'b1, 1'b0, 3'b000, 32'h41, 32'h0,        1'b1, 32'hFFFFFFAB, 0);
      set_vec( 4, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0,        1'b1, 32'h1111AB11, 0);
      set_vec( 5, 1'b1, 1'b0, 3'b010, 32'h4C, 32'h0,        1'b1, 32'h44444444, 0);
      set_vec( 6, 1'b1, 1'b0, 3'b100, 32'h43, 32'h0,        1'b1, 32'h00000011, 0);
      set_vec( 7, 1'b1, 1'b0, 3'b101, 32'h40, 32'h0,        1'b1, 32'h0000AB11, 0);
      set_vec( 8, 1'b0, 1'b1, 3'b010, 32'hC0, 32'hCAFEF00D, 1'b0, 32'h0,        9);
      set_vec( 9, 1'b1, 1'b0, 3'b010, 32'hC0, 32'h0,        1'b1, 32'hCAFEF00D, 0);
      set_vec(10, 1'b1, 1'b0, 3'b010, 32'hC4, 32'h0,        1'b1, 32'hBBBBBBBB, 0);
      set_vec(11, 1'b0, 1'b1, 3'b001, 32'hC2, 32'hFFFF8001, 1'b0, 32'h0,        0);
      set_vec(12, 1'b1, 1'b0, 3'b001, 32'hC2, 32'h0,        1'b1, 32'hFFFF8001, 0);
      set_vec(13, 1'b1, 1'b0, 3'b101, 32'hC2, 32'h0,        1'b1, 32'h00008001, 0);
      set_vec(14, 1'b1, 1'b0, 3'b001, 32'hC3, 32'h0,        1'b1, 32'hFFFF8001, 0);
      set_vec(15, 1'b1, 1'b0, 3'b000, 32'hC3, 32'h0,        1'b1, 32'hFFFFFF80, 0);
      set_vec(16, 1'b0, 1'b1, 3'b010, 32'hC8, 32'h12345678, 1'b0, 32'h0,        0);
      set_vec(17, 1'b1, 1'b0, 3'b011, 32'hCB, 32'h0,        1'b1, 32'h12345678, 0);
      set_vec(18, 1'b1, 1'b1, 3'b000, 32'hC4, 32'h0000005A, 1'b0, 32'h0,        0);
      set_vec(19, 1'b1, 1'b0, 3'b010, 32'hC4, 32'h0,        1'b1, 32'hBBBBBB5A, 0);
      set_vec(20, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0,        1'b1, 32'h1111AB11, 9);
      set_vec(21, 1'b1, 1'b0, 3'b000, 32'h4C, 32'h0,        1'b1, 32'h00000044, 0);

      // Reset state
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("rst_busywait",  128'(bus.BUSYWAIT),      128'd0);
      check("rst_mem_read",  128'(bus.MEM_READ),      128'd0);
      check("rst_mem_write", 128'(bus.MEM_WRITE),     128'd0);
      check("rst_readdata",  128'(bus.READDATA),      128'd0);
      check("rst_mem_addr",  128'(bus.MEM_ADDRESS),   128'd0);
      check("rst_mem_wdata", bus.MEM_WRITEDATA,       128'd0);
      check("rst_state",     128'(state_dbg),         128'd0);
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      @(negedge CLK);
      check("post_rst_busywait", 128'(bus.BUSYWAIT), 128'd0);
      @(posedge CLK);
      #1;

      // Clean miss on 0x40
      run_vec(0);
      check("miss0_saw_rd",  128'(saw_rd),  128'd1);
      check("miss0_rd_addr", 128'(rd_addr), 128'h4);
      check("miss0_saw_wr",  128'(saw_wr),  128'd0);

      for (int i = 1; i <= 7; i++) run_vec(i);

      // Dirty eviction of line 4 by a store to 0xC0
      run_vec(8);
      check("evict4_saw_wr",  128'(saw_wr),  128'd1);
      check("evict4_wr_addr", 128'(wr_addr), 128'h4);
      check("evict4_wr_data", wr_data, 128'h44444444_33333333_22222222_1111AB11);
      check("evict4_rd_addr", 128'(rd_addr), 128'hC);

      for (int i = 9; i <= 19; i++) run_vec(i);

      // Evict dirty block C; refetched block 4 must carry the earlier writeback
      run_vec(20);
      check("evictC_wr_addr", 128'(wr_addr), 128'hC);
      check("evictC_wr_data", wr_data, 128'hDDDDDDDD_12345678_BBBBBB5A_8001F00D);
      check("evictC_rd_addr", 128'(rd_addr), 128'h4);
      run_vec(21);

      // Store dropped during FETCH: line still filled, store not applied
      bus.READ = 1'b0;  bus.WRITE = 1'b1;  bus.FUNCT3 = 3'b010;
      bus.ADDRESS = 32'h80;  bus.WRITEDATA = 32'hDEADBEEF;
      wait_mem_read("drop_wait_mem_read");
      @(posedge CLK);
      #1;
      bus.WRITE = 1'b0;
      n = 0;
      @(negedge CLK);
      while (bus.BUSYWAIT && n < 30) begin
         n++;
         @(negedge CLK);
      end
      check("drop_busy_clears", 128'(bus.BUSYWAIT), 128'd0);
      @(posedge CLK);
      #1;
      do_access(1'b1, 1'b0, 3'b010, 32'h80, 32'h0, stall, rdata);
      check("drop_reload_stall", 128'(stall), 128'd0);
      check("drop_reload_data",  128'(rdata), 128'h55555555);

      // Reset asserted while in FETCH
      bus.READ = 1'b1;  bus.WRITE = 1'b0;  bus.FUNCT3 = 3'b010;  bus.ADDRESS = 32'h180;
      wait_mem_read("rstfetch_wait_mem_read");
      check("rstfetch_state_fetch", 128'(state_dbg), 128'd2);
      @(posedge CLK);
      #1;
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      bus.READ = 1'b0;
      @(negedge CLK);
      check("rstfetch_mem_read", 128'(bus.MEM_READ), 128'd0);
      check("rstfetch_busywait", 128'(bus.BUSYWAIT), 128'd0);
      check("rstfetch_state",    128'(state_dbg),    128'd0);
      @(posedge CLK);
      #1;
      do_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, stall, rdata);
      check("rstfetch_remiss_stall", 128'(stall), 128'd5);
      check("rstfetch_remiss_data",  128'(rdata), 128'h1111AB11);

      // Counters: one miss then three hits from a fresh reset
      RESET = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;
`ifdef DCACHE_STATS_EN
      @(negedge CLK);
      check("stats_rst_hit",  128'(HIT_COUNT),  128'd0);
      check("stats_rst_miss", 128'(MISS_COUNT), 128'd0);
      @(posedge CLK);
      #1;
`endif
      do_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, stall, rdata);
      check("stats_miss_stall", 128'(stall), 128'd5);
      do_access(1'b1, 1'b0, 3'b010, 32'h44, 32'h0, stall, rdata);
      check("stats_hit1_data", 128'(rdata), 128'h22222222);
      do_access(1'b1, 1'b0, 3'b010, 32'h48, 32'h0, stall, rdata);
      check("stats_hit2_data", 128'(rdata), 128'h33333333);
      do_access(1'b1, 1'b0, 3'b100, 32'h41, 32'h0, stall, rdata);
      check("stats_hit3_data", 128'(rdata), 128'h000000AB);
`ifdef DCACHE_STATS_EN
      @(negedge CLK);
      check("stats_hit_count",  128'(HIT_COUNT),  128'd3);
      check("stats_miss_count", 128'(MISS_COUNT), 128'd1);
`endif

      check("mem_req_overlap", 128'(both_high), 128'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
